// File: rtl/tx_framer.sv
// Transmit byte framer: K28.5 alignment preamble after reset, then each accepted
// word is sliced LSB byte first into symbol slots, with K28.5 filling idle slots.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PREAMBULO | sending the post-reset K28.5 run, no words accepted
// IDLE      | between words, launches K28.5 unless a word is held
// DATOS     | launching the remaining bytes of the held word
module tx_framer #(
  parameter int SYM_CYCLES   = 10,
  parameter int PREAMBLE_LEN = 4
) (
  input  logic        clkTx,
  input  logic        rst,
  input  logic        enb,
  input  logic [1:0]  dataS,
  input  logic [31:0] dataIn,
  input  logic        dataValid,
  output logic        dataReady,
  output logic [7:0]  dataOut,
  output logic        k_out,
  output logic        symStrobe,
  output logic        preambuloListo
);

  localparam int CW = $clog2(SYM_CYCLES);
  localparam int RW = $clog2(PREAMBLE_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SYM_CYCLES - 1);
  localparam logic [RW-1:0] REM_INIT = RW'(PREAMBLE_LEN);
  localparam logic [7:0]    K28_5    = 8'hBC;

  typedef enum logic [1:0] {PREAMBULO, IDLE, DATOS} state_t;

  state_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          pre_done_q, pre_done_d;
  logic          occ_q, occ_d;
  logic [31:0]   word_q, word_d;
  logic [2:0]    nbytes_q, nbytes_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    dout_q, dout_d;
  logic          k_q, k_d;
  logic          strobe_q, strobe_d;
  logic          ready_q, ready_d;
  logic          boundary;
  logic          accept;
  logic [7:0]    cur_byte;

  always_comb begin
    case (idx_q)
      2'd0:    cur_byte = word_q[7:0];
      2'd1:    cur_byte = word_q[15:8];
      2'd2:    cur_byte = word_q[23:16];
      default: cur_byte = word_q[31:24];
    endcase
  end

  always_comb begin
    boundary   = enb && (cnt_q == CNT_LAST);
    accept     = enb && dataValid && ready_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    pre_done_d = pre_done_q;
    occ_d      = occ_q;
    word_d     = word_q;
    nbytes_d   = nbytes_q;
    idx_d      = idx_q;
    dout_d     = dout_q;
    k_d        = k_q;
    strobe_d   = boundary;

    if (enb) begin
      cnt_d = boundary ? '0 : cnt_q + 1'b1;
    end

    if (boundary) begin
      case (state_q)
        PREAMBULO: begin
          // no word can be held yet, so the slot after the preamble is always an idle comma
          dout_d = K28_5;
          k_d    = 1'b1;
          if (rem_q != '0) begin
            rem_d = rem_q - 1'b1;
          end else begin
            pre_done_d = 1'b1;
            state_d    = IDLE;
          end
        end
        IDLE: begin
          if (occ_q) begin
            dout_d = word_q[7:0];
            k_d    = 1'b0;
            if (nbytes_q == 3'd1) begin
              occ_d = 1'b0;
            end else begin
              idx_d   = 2'd1;
              state_d = DATOS;
            end
          end else begin
            dout_d = K28_5;
            k_d    = 1'b1;
          end
        end
        DATOS: begin
          dout_d = cur_byte;
          k_d    = 1'b0;
          idx_d  = idx_q + 2'd1;
          if ({1'b0, idx_q} == nbytes_q - 3'd1) begin
            occ_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = PREAMBULO;
      endcase
    end

    // acceptance needs occ_q low, so it never collides with the last-byte clear above
    if (accept) begin
      word_d = dataIn;
      occ_d  = 1'b1;
      case (dataS)
        2'b01:   nbytes_d = 3'd2;
        2'b10:   nbytes_d = 3'd4;
        default: nbytes_d = 3'd1;
      endcase
    end

    ready_d = pre_done_d && !occ_d;
  end

  always_ff @(posedge clkTx or negedge rst) begin
    if (!rst) begin
      state_q    <= PREAMBULO;
      cnt_q      <= CNT_LAST;
      rem_q      <= REM_INIT;
      pre_done_q <= 1'b0;
      occ_q      <= 1'b0;
      word_q     <= '0;
      nbytes_q   <= 3'd1;
      idx_q      <= 2'd0;
      dout_q     <= K28_5;
      k_q        <= 1'b1;
      strobe_q   <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      pre_done_q <= pre_done_d;
      occ_q      <= occ_d;
      word_q     <= word_d;
      nbytes_q   <= nbytes_d;
      idx_q      <= idx_d;
      dout_q     <= dout_d;
      k_q        <= k_d;
      strobe_q   <= strobe_d;
      ready_q    <= ready_d;
    end
  end

  assign dataOut        = dout_q;
  assign k_out          = k_q;
  assign symStrobe      = strobe_q && enb;
  assign dataReady      = ready_q;
  assign preambuloListo = pre_done_q;

endmodule

// File: tb/tb_tx_framer.sv
// Bench for tx_framer: data bytes are queued when a word is offered and popped
// by a monitor as each non-K symbol launches; scenario tasks check slot timing.
module tb_tx_framer;

  logic        clkTx = 1'b0;
  logic        rst;
  logic        enb;
  logic [1:0]  dataS;
  logic [31:0] dataIn;
  logic        dataValid;
  logic        dataReady;
  logic [7:0]  dataOut;
  logic        k_out;
  logic        symStrobe;
  logic        preambuloListo;

  int          tests = 0;
  int          fails = 0;
  int          edge_n = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  sb_exp;

  tx_framer #(.SYM_CYCLES(10), .PREAMBLE_LEN(4)) dut (
    .clkTx(clkTx), .rst(rst), .enb(enb), .dataS(dataS), .dataIn(dataIn),
    .dataValid(dataValid), .dataReady(dataReady), .dataOut(dataOut),
    .k_out(k_out), .symStrobe(symStrobe), .preambuloListo(preambuloListo)
  );

  always #5 clkTx = ~clkTx;

  always @(posedge clkTx) begin
    #1;
    if (symStrobe && !k_out) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: edge %0d got data byte %h, none expected", edge_n, dataOut);
      end else begin
        sb_exp = exp_q.pop_front();
        if (dataOut !== sb_exp) begin
          fails++;
          $display("FAIL sb_byte: edge %0d got %h, expected %h", edge_n, dataOut, sb_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clkTx);
    if (rst) edge_n++;
    #1;
  endtask

  task automatic go_to(input int n);
    int guard;
    guard = 0;
    while (edge_n < n && guard < 2000) begin
      tick();
      guard++;
    end
  endtask

  task automatic offer(input logic [1:0] s, input logic [31:0] d);
    dataS     = s;
    dataIn    = d;
    dataValid = 1'b1;
    tick();
    dataValid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; enb = 1'b0; dataValid = 1'b0; dataS = 2'b00; dataIn = '0;
    repeat (3) @(posedge clkTx);
    #1;
    tests++;
    if ({dataOut, k_out, symStrobe, dataReady, preambuloListo} !== {8'hBC, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_vals: got %h/%b/%b/%b/%b, expected bc/1/0/0/0",
               dataOut, k_out, symStrobe, dataReady, preambuloListo);
    end
  endtask

  // valid held high through the preamble must not capture anything
  task automatic test_preamble();
    logic s, p;
    dataS = 2'b10; dataIn = 32'h1234_5678; dataValid = 1'b1;
    rst = 1'b1; enb = 1'b1; edge_n = 0;
    for (int e = 1; e <= 41; e++) begin
      tick();
      s = (e % 10 == 1);
      p = (e == 41);
      tests++;
      if ({dataOut, k_out, symStrobe, dataReady, preambuloListo} !== {8'hBC, 1'b1, s, p, p}) begin
        fails++;
        $display("FAIL preamble edge %0d: got %h/%b/%b/%b/%b, expected bc/1/%b/%b/%b",
                 e, dataOut, k_out, symStrobe, dataReady, preambuloListo, s, p, p);
      end
      if (e == 40) dataValid = 1'b0;
    end
  endtask

  task automatic test_word32();
    go_to(42);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    offer(2'b10, 32'h4433_2211);
    tests++;
    if (dataReady !== 1'b0) begin fails++; $display("FAIL w32_busy: ready %b, expected 0", dataReady); end
    go_to(51);
    tests++;
    if ({dataOut, k_out, symStrobe} !== {8'h11, 1'b0, 1'b1}) begin
      fails++; $display("FAIL w32_first: got %h/%b/%b, expected 11/0/1", dataOut, k_out, symStrobe);
    end
    go_to(80);
    tests++;
    if (dataReady !== 1'b0) begin fails++; $display("FAIL w32_busy80: ready %b, expected 0", dataReady); end
    go_to(81);
    tests++;
    if ({dataOut, k_out, dataReady} !== {8'h44, 1'b0, 1'b1}) begin
      fails++; $display("FAIL w32_last: got %h/%b ready %b, expected 44/0 ready 1", dataOut, k_out, dataReady);
    end
    go_to(91);
    tests++;
    if ({dataOut, k_out, symStrobe} !== {8'hBC, 1'b1, 1'b1}) begin
      fails++; $display("FAIL w32_idle: got %h/%b/%b, expected bc/1/1", dataOut, k_out, symStrobe);
    end
  endtask

  task automatic test_back_to_back();
    go_to(92);
    exp_q.push_back(8'hBB); exp_q.push_back(8'hAA);
    offer(2'b01, 32'h5555_AABB);
    go_to(101);
    tests++;
    if ({dataOut, k_out} !== {8'hBB, 1'b0}) begin
      fails++; $display("FAIL b2b_b0: got %h/%b, expected bb/0", dataOut, k_out);
    end
    go_to(111);
    tests++;
    if ({dataOut, k_out, dataReady} !== {8'hAA, 1'b0, 1'b1}) begin
      fails++; $display("FAIL b2b_b1: got %h/%b ready %b, expected aa/0 ready 1", dataOut, k_out, dataReady);
    end
    exp_q.push_back(8'hDD); exp_q.push_back(8'hCC);
    offer(2'b01, 32'h0000_CCDD);
    tests++;
    if (dataReady !== 1'b0) begin fails++; $display("FAIL b2b_busy: ready %b, expected 0", dataReady); end
    go_to(121);
    tests++;
    if ({dataOut, k_out, symStrobe} !== {8'hDD, 1'b0, 1'b1}) begin
      fails++; $display("FAIL b2b_nogap: got %h/%b/%b, expected dd/0/1", dataOut, k_out, symStrobe);
    end
    go_to(131);
    tests++;
    if ({dataOut, k_out, dataReady} !== {8'hCC, 1'b0, 1'b1}) begin
      fails++; $display("FAIL b2b_last: got %h/%b ready %b, expected cc/0 ready 1", dataOut, k_out, dataReady);
    end
  endtask

  task automatic test_width();
    exp_q.push_back(8'h5A);
    offer(2'b11, 32'hFFFF_FF5A);
    go_to(141);
    tests++;
    if ({dataOut, k_out, dataReady} !== {8'h5A, 1'b0, 1'b1}) begin
      fails++; $display("FAIL w8_byte: got %h/%b ready %b, expected 5a/0 ready 1", dataOut, k_out, dataReady);
    end
    // acceptance on a boundary edge waits for the following slot; bc as data keeps k=0
    go_to(150);
    exp_q.push_back(8'hBC); exp_q.push_back(8'h77);
    offer(2'b01, 32'hFFFF_77BC);
    tests++;
    if ({dataOut, k_out, symStrobe, dataReady} !== {8'hBC, 1'b1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL same_edge_idle: got %h/%b/%b ready %b, expected bc/1/1 ready 0",
                        dataOut, k_out, symStrobe, dataReady);
    end
    go_to(161);
    tests++;
    if ({dataOut, k_out, symStrobe} !== {8'hBC, 1'b0, 1'b1}) begin
      fails++; $display("FAIL bc_data: got %h/%b/%b, expected bc/0/1", dataOut, k_out, symStrobe);
    end
    go_to(171);
    tests++;
    if ({dataOut, k_out, dataReady} !== {8'h77, 1'b0, 1'b1}) begin
      fails++; $display("FAIL w16_last: got %h/%b ready %b, expected 77/0 ready 1", dataOut, k_out, dataReady);
    end
  endtask

  task automatic test_enb();
    go_to(182);
    exp_q.push_back(8'hD4); exp_q.push_back(8'hC3); exp_q.push_back(8'hB2); exp_q.push_back(8'hA1);
    offer(2'b10, 32'hA1B2_C3D4);
    go_to(192);
    enb = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      tests++;
      if ({dataOut, k_out, symStrobe} !== {8'hD4, 1'b0, 1'b0}) begin
        fails++; $display("FAIL enb_freeze edge %0d: got %h/%b/%b, expected d4/0/0", edge_n, dataOut, k_out, symStrobe);
      end
    end
    enb = 1'b1;
    go_to(201);
    tests++;
    if ({dataOut, symStrobe} !== {8'hD4, 1'b0}) begin
      fails++; $display("FAIL enb_not_early: got %h/%b, expected d4/0", dataOut, symStrobe);
    end
    go_to(208);
    tests++;
    if ({dataOut, k_out, symStrobe} !== {8'hC3, 1'b0, 1'b1}) begin
      fails++; $display("FAIL enb_late: got %h/%b/%b, expected c3/0/1", dataOut, k_out, symStrobe);
    end
    go_to(228);
    tests++;
    if ({dataOut, dataReady} !== {8'hA1, 1'b1}) begin
      fails++; $display("FAIL enb_last: got %h ready %b, expected a1 ready 1", dataOut, dataReady);
    end
    go_to(238);
    tests++;
    if ({dataOut, k_out, symStrobe} !== {8'hBC, 1'b1, 1'b1}) begin
      fails++; $display("FAIL enb_idle: got %h/%b/%b, expected bc/1/1", dataOut, k_out, symStrobe);
    end
  endtask

  task automatic test_reset_mid_word();
    go_to(239);
    exp_q.push_back(8'h0A); exp_q.push_back(8'h0B); exp_q.push_back(8'h0C); exp_q.push_back(8'h0D);
    offer(2'b10, 32'h0D0C_0B0A);
    go_to(262);
    rst = 1'b0;
    #1;
    tests++;
    if ({dataOut, k_out, symStrobe, dataReady, preambuloListo} !== {8'hBC, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: got %h/%b/%b/%b/%b, expected bc/1/0/0/0",
               dataOut, k_out, symStrobe, dataReady, preambuloListo);
    end
    exp_q.delete();
    repeat (2) @(posedge clkTx);
    #1;
    test_preamble();
    go_to(42);
    exp_q.push_back(8'h3C);
    offer(2'b00, 32'hEEEE_EE3C);
    go_to(51);
    tests++;
    if ({dataOut, k_out, dataReady} !== {8'h3C, 1'b0, 1'b1}) begin
      fails++; $display("FAIL post_reset_word: got %h/%b ready %b, expected 3c/0 ready 1", dataOut, k_out, dataReady);
    end
    go_to(61);
    tests++;
    if ({dataOut, k_out} !== {8'hBC, 1'b1}) begin
      fails++; $display("FAIL post_reset_idle: got %h/%b, expected bc/1", dataOut, k_out);
    end
  endtask

  initial begin
    test_reset();
    test_preamble();
    test_word32();
    test_back_to_back();
    test_width();
    test_enb();
    test_reset_mid_word();
    go_to(70);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL sb_leftover: %0d bytes never launched, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
